cpu_debug_scan_ctrl: RTL and testbench
======================================

CPU_DEBUG_SCAN_CTRL -- requirements
Module: cpu_debug_scan_ctrl

Interface
REQ-001 Parameter DATA_W, default 38, SHALL set the data-register scan length in bits (range 8..64).
REQ-002 Parameter IR_W, default 2, SHALL set the instruction width; N_IR = 2**IR_W instructions.
REQ-003 Parameter ACT_BIT, default DATA_W-1, SHALL select the jdo bit that distinguishes action from no-action on update.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ir_in  in  IR_W  instruction value, sampled on vs_uir.
REQ-007 vs_uir  in  1  update-IR strobe, one cycle.
REQ-008 vs_cdr  in  1  capture-DR strobe, one cycle.
REQ-009 vs_sdr  in  1  shift-DR strobe, one cycle per bit.
REQ-010 vs_udr  in  1  update-DR strobe, one cycle.
REQ-011 tdi  in  1  serial input bit, valid with vs_sdr.
REQ-012 cap_data  in  N_IR*DATA_W  capture sources, slice i = instruction i.
REQ-013 tdo  out  1  sr[0], serial output.
REQ-014 jdo  out  DATA_W  data register latched on accepted update.
REQ-015 ir_q  out  IR_W  current instruction.
REQ-016 take_action  out  N_IR  one-hot, one-cycle strobe.
REQ-017 take_no_action  out  N_IR  one-hot, one-cycle strobe.
REQ-018 len_err  out  1  sticky: last update had wrong bit count.
REQ-019 busy  out  1  high in CAPTURED or SHIFTING.

Function
REQ-020 FSM SHALL have states IDLE, CAPTURED, SHIFTING, UPDATE.
REQ-021 IDLE: vs_cdr -> load sr <= cap_data slice[ir_q], bit_cnt <= 0, go CAPTURED.
REQ-022 CAPTURED/SHIFTING: each vs_sdr -> sr <= {tdi, sr[DATA_W-1:1]}, bit_cnt++ saturating at DATA_W+1, state SHIFTING.
REQ-023 vs_udr in CAPTURED/SHIFTING -> UPDATE for exactly one cycle, then IDLE.
REQ-024 On entering UPDATE with bit_cnt == DATA_W: jdo <= sr, len_err <= 0; in the UPDATE cycle (one cycle after vs_udr) exactly one bit ir_q of take_action (if sr[ACT_BIT]=1) or take_no_action (if 0) SHALL pulse.
REQ-025 bit_cnt != DATA_W at vs_udr (including 0): jdo unchanged, no strobe, len_err <= 1.
REQ-026 vs_udr in IDLE SHALL be ignored (no strobe, no flag change).
REQ-027 vs_uir in any state: ir_q <= ir_in, state <= IDLE, shift aborted, no strobe; bit_cnt <= 0.
REQ-028 Simultaneous strobes priority: vs_uir > vs_udr > vs_cdr > vs_sdr; lower ones dropped that cycle.
REQ-029 vs_cdr while CAPTURED/SHIFTING SHALL recapture (restart) per REQ-021.
REQ-030 vs_sdr in IDLE SHALL shift sr but not change state or bit_cnt.
REQ-031 take_action and take_no_action SHALL never both be nonzero; each is registered.
REQ-032 Latency: tdo reflects new sr[0] the cycle after the capture/shift strobe.

Reset
REQ-033 reset SHALL give: state IDLE, sr=0, jdo=0, ir_q=0, bit_cnt=0, all strobes 0, len_err=0, busy=0, tdo=0.
REQ-034 reset asserted mid-shift or in UPDATE SHALL suppress any pending strobe that cycle and onward.

Verification
REQ-035 uir ir_in=2; cdr; 38 sdr with tdi pattern setting bit37=1; udr -> jdo=pattern, take_action=4'b0100 one cycle, len_err=0.
REQ-036 Same with bit37=0 -> take_no_action=4'b0100, take_action=0.
REQ-037 cdr, 37 sdr, udr -> no strobe, jdo unchanged, len_err=1; next correct 38-bit scan clears it.
REQ-038 ir_q=1, cap_data slice1=0x2A_5555_AAAA; cdr, 38 sdr -> tdo stream equals slice LSB first.
REQ-039 uir and udr same cycle after 38 shifts -> ir_q updated, no strobe, state IDLE.
REQ-040 reset at shift 20, then udr -> no strobe, all outputs at reset values.

Source files
------------

// File: rtl/cpu_debug_scan_ctrl.sv
// Debug scan-chain controller: captures a per-instruction source into a shift register,
// shifts it out LSB first, and on a correct-length update latches jdo and fires a strobe.
module cpu_debug_scan_ctrl #(
  parameter int unsigned DATA_W  = 38,
  parameter int unsigned IR_W    = 2,
  parameter int unsigned ACT_BIT = DATA_W - 1,
  localparam int unsigned N_IR   = 2 ** IR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   vs_uir,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic                   tdi,
  input  logic [N_IR*DATA_W-1:0] cap_data,
  output logic                   tdo,
  output logic [DATA_W-1:0]      jdo,
  output logic [IR_W-1:0]        ir_q,
  output logic [N_IR-1:0]        take_action,
  output logic [N_IR-1:0]        take_no_action,
  output logic                   len_err,
  output logic                   busy
);

  // Counter must represent DATA_W+1 so overshoot is distinguishable from an exact fit.
  localparam int unsigned CntW = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {StIdle, StCaptured, StShifting, StUpdate} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   sr_q;
  logic [DATA_W-1:0]   jdo_q;
  logic [IR_W-1:0]     ir_sel_q;
  logic [CntW-1:0]     cnt_q;
  logic [N_IR-1:0]     act_q;
  logic [N_IR-1:0]     noact_q;
  logic                len_err_q;

  logic [DATA_W-1:0]   cap_slice;
  logic [N_IR-1:0]     ir_onehot;
  logic                scanning;

  assign cap_slice = cap_data[ir_sel_q * DATA_W +: DATA_W];
  assign ir_onehot = N_IR'(1) << ir_sel_q;
  assign scanning  = (state_q == StCaptured) || (state_q == StShifting);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      jdo_q     <= '0;
      ir_sel_q  <= '0;
      cnt_q     <= '0;
      act_q     <= '0;
      noact_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      act_q   <= '0;
      noact_q <= '0;
      if (vs_uir) begin
        ir_sel_q <= ir_in;
        cnt_q    <= '0;
        state_q  <= StIdle;
      end else begin
        case (state_q)
          StIdle, StCaptured, StShifting: begin
            // A udr strobe outranks cdr/sdr even in idle, where it has no other effect.
            if (vs_udr) begin
              if (scanning) begin
                state_q <= StUpdate;
                if (cnt_q == CntW'(DATA_W)) begin
                  jdo_q     <= sr_q;
                  len_err_q <= 1'b0;
                  if (sr_q[ACT_BIT]) begin
                    act_q <= ir_onehot;
                  end else begin
                    noact_q <= ir_onehot;
                  end
                end else begin
                  len_err_q <= 1'b1;
                end
              end
            end else if (vs_cdr) begin
              sr_q    <= cap_slice;
              cnt_q   <= '0;
              state_q <= StCaptured;
            end else if (vs_sdr) begin
              sr_q <= {tdi, sr_q[DATA_W-1:1]};
              if (scanning) begin
                state_q <= StShifting;
                if (cnt_q != CntW'(DATA_W + 1)) begin
                  cnt_q <= cnt_q + CntW'(1);
                end
              end
            end
          end
          // Strobes arriving during the single update cycle are dropped.
          StUpdate: state_q <= StIdle;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

  assign tdo            = sr_q[0];
  assign jdo            = jdo_q;
  assign ir_q           = ir_sel_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign len_err        = len_err_q;
  assign busy           = scanning;

endmodule

// File: tb/tb_cpu_debug_scan_ctrl.sv
// Bench for cpu_debug_scan_ctrl: directed scans with literal expectations, then random
// scans compared every cycle against a transaction-level model.
module tb_cpu_debug_scan_ctrl;

  localparam int DW  = 38;
  localparam int IRW = 2;
  localparam int NIR = 4;
  localparam int ACT = DW - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [IRW-1:0]     ir_in = '0;
  logic               vs_uir = 1'b0, vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0, tdi = 1'b0;
  logic [NIR*DW-1:0]  cap_data = '0;
  logic               tdo, len_err, busy;
  logic [DW-1:0]      jdo;
  logic [IRW-1:0]     ir_q;
  logic [NIR-1:0]     take_action, take_no_action;

  cpu_debug_scan_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .tdi            (tdi),
    .cap_data       (cap_data),
    .tdo            (tdo),
    .jdo            (jdo),
    .ir_q           (ir_q),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .len_err        (len_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: scan register contents, bits shifted since capture, and two phase flags.
  logic [DW-1:0]  m_sr, m_jdo;
  logic [IRW-1:0] m_ir;
  logic [NIR-1:0] m_act, m_noact;
  logic           m_len;
  int             m_cnt;
  bit             m_active, m_upd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_act   = '0;
    m_noact = '0;
    if (reset) begin
      m_sr = '0; m_jdo = '0; m_ir = '0; m_cnt = 0; m_len = 1'b0;
      m_active = 1'b0; m_upd = 1'b0;
    end else if (vs_uir) begin
      m_ir = ir_in; m_cnt = 0; m_active = 1'b0; m_upd = 1'b0;
    end else if (m_upd) begin
      m_upd = 1'b0;
    end else if (vs_udr) begin
      if (m_active) begin
        m_active = 1'b0;
        m_upd    = 1'b1;
        if (m_cnt == DW) begin
          m_jdo = m_sr;
          m_len = 1'b0;
          if (m_sr[ACT]) m_act = NIR'(1) << m_ir;
          else           m_noact = NIR'(1) << m_ir;
        end else begin
          m_len = 1'b1;
        end
      end
    end else if (vs_cdr) begin
      m_sr = cap_data[m_ir * DW +: DW];
      m_cnt = 0;
      m_active = 1'b1;
    end else if (vs_sdr) begin
      m_sr = {tdi, m_sr[DW-1:1]};
      if (m_active && m_cnt < DW + 1) m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input logic uir, input logic cdr, input logic sdr, input logic udr,
                     input logic t, input logic [IRW-1:0] ir);
    vs_uir = uir; vs_cdr = cdr; vs_sdr = sdr; vs_udr = udr; tdi = t; ir_in = ir;
    tick();
    vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
  endtask

  task automatic scan(input logic [DW-1:0] pat, input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b1, 1'b0, (i < DW) ? pat[i] : 1'b0, 2'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      chk("tdo", 64'(tdo), 64'(m_sr[0]));
      chk("jdo", 64'(jdo), 64'(m_jdo));
      chk("ir_q", 64'(ir_q), 64'(m_ir));
      chk("take_action", 64'(take_action), 64'(m_act));
      chk("take_no_action", 64'(take_no_action), 64'(m_noact));
      chk("len_err", 64'(len_err), 64'(m_len));
      chk("busy", 64'(busy), 64'(m_active));
      chk("strobe_excl", 64'((take_action != 0) && (take_no_action != 0)), 64'd0);
    end
  end

  logic [DW-1:0] p1, p2, s1;

  initial begin
    p1 = 38'h2A_1234_5678;  // bit 37 set
    p2 = 38'h15_0F0F_F0F0;  // bit 37 clear
    s1 = 38'h2A_5555_AAAA;
    for (int j = 0; j < NIR; j++) cap_data[j*DW +: DW] = DW'({$urandom(), $urandom()});

    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_en = 1'b1;
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_ir", 64'(ir_q), 64'd0);
    chk("rst_busy_tdo", 64'({busy, tdo, len_err}), 64'd0);
    reset = 1'b0;

    // Correct-length scan with action bit set.
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("cap_busy", 64'(busy), 64'd1);
    scan(p1, DW);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("act_jdo", 64'(jdo), 64'h2A_1234_5678);
    chk("act_strobe", 64'(take_action), 64'b0100);
    chk("act_noact", 64'(take_no_action), 64'd0);
    chk("act_len", 64'(len_err), 64'd0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("act_oneshot", 64'(take_action), 64'd0);

    // Same with action bit clear.
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    scan(p2, DW);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("noact_strobe", 64'(take_no_action), 64'b0100);
    chk("noact_act", 64'(take_action), 64'd0);
    chk("noact_jdo", 64'(jdo), 64'h15_0F0F_F0F0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Short scan flags len_err, then a good scan clears it.
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    scan(p1, DW - 1);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("short_len", 64'(len_err), 64'd1);
    chk("short_jdo", 64'(jdo), 64'h15_0F0F_F0F0);
    chk("short_strobes", 64'({take_action, take_no_action}), 64'd0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    scan(p1, DW);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("clear_len", 64'(len_err), 64'd0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Capture stream on instruction 1 comes out LSB first.
    cap_data[1*DW +: DW] = s1;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < DW; k++) begin
      chk("tdo_stream", 64'(tdo), 64'(s1[k]));
      drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    end

    // uir and udr together: uir wins, no strobe.
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    scan(p1, DW);
    drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    chk("uir_udr_ir", 64'(ir_q), 64'd3);
    chk("uir_udr_strobes", 64'({take_action, take_no_action}), 64'd0);
    chk("uir_udr_busy", 64'(busy), 64'd0);

    // Reset mid-shift, then udr.
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    scan(p1, 20);
    reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("rst_mid_strobes", 64'({take_action, take_no_action}), 64'd0);
    chk("rst_mid_jdo", 64'(jdo), 64'd0);
    chk("rst_mid_misc", 64'({ir_q, busy, tdo, len_err}), 64'd0);

    // Random transactions with collisions, idle shifts and occasional resets.
    for (int t = 0; t < 150; t++) begin
      int n;
      for (int j = 0; j < NIR; j++) cap_data[j*DW +: DW] = DW'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0)
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IRW'($urandom_range(0, NIR - 1)));
      if ($urandom_range(0, 5) == 0)
        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom()), 2'd0);
      drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      n = ($urandom_range(0, 1) == 1) ? DW : $urandom_range(0, DW + 6);
      for (int i = 0; i < n; i++)
        drv($urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0, 1'b1,
            $urandom_range(0, 79) == 0, 1'($urandom()), IRW'($urandom_range(0, NIR - 1)));
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
      end
      drv(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'($urandom()), 2'd0);
      drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      if ($urandom_range(0, 7) == 0) begin
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      end
    end

    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
